// File: rtl/fifo_ram_ctrl_if.sv
// Bundle of the FIFO controller's signals: producer side, consumer side, status and RAM port.
// Latency: pure wiring; no storage in this file.
// Backpressure: the producer watches full/almost_full; the consumer watches empty/rd_valid.
//
// Signal summary
//   producer : wr_en, wr_data -> ctrl ; full, almost_full <- ctrl
//   consumer : rd_en -> ctrl ; rd_data, rd_valid, empty, count <- ctrl
//   status   : overflow, underflow (sticky) <- ctrl
//   ram port : ram_wen, ram_w_addr, ram_w_data, ram_ren, ram_r_addr <- ctrl ; ram_r_data -> ctrl
// The master side is the environment: the producer, the consumer and the RAM.
// The slave side is the controller.
interface fifo_ram_ctrl_if #(
  parameter int DW = 32,
  parameter int AW = 4
);
  // producer
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          almost_full;
  // consumer
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          empty;
  logic [AW:0]   count;
  // sticky error status
  logic          overflow;
  logic          underflow;
  // storage RAM port
  logic          ram_wen;
  logic [AW-1:0] ram_w_addr;
  logic [DW-1:0] ram_w_data;
  logic          ram_ren;
  logic [AW-1:0] ram_r_addr;
  logic [DW-1:0] ram_r_data;

  modport master (
    output wr_en, wr_data, rd_en, ram_r_data,
    input  full, almost_full, rd_data, rd_valid, empty, count,
           overflow, underflow,
           ram_wen, ram_w_addr, ram_w_data, ram_ren, ram_r_addr
  );

  modport slave (
    input  wr_en, wr_data, rd_en, ram_r_data,
    output full, almost_full, rd_data, rd_valid, empty, count,
           overflow, underflow,
           ram_wen, ram_w_addr, ram_w_data, ram_ren, ram_r_addr
  );
endinterface

// File: rtl/fifo_ram_ctrl.sv
// Synchronous FIFO controller that keeps its storage in an external dual-port RAM.
// Latency: one cycle from an accepted read to rd_valid/rd_data. A write is visible to reads on the next cycle.
// Backpressure: writes while full and reads while empty are dropped and flagged as sticky overflow/underflow.
//
// Ports
//   clk  : rising-edge clock
//   rstn : synchronous active-low reset
//   bus  : fifo_ram_ctrl_if.slave; producer, consumer, status and RAM-port signals
// Pointers are AW+1 bits wide. The low AW bits address the RAM. The MSB is a wrap
// bit, so full and empty can be told apart when the low bits match.
module fifo_ram_ctrl #(
  parameter int DW     = 32,
  parameter int AW     = 4,
  parameter int AF_LVL = 12
) (
  input  logic           clk,
  input  logic           rstn,
  fifo_ram_ctrl_if.slave bus
);

  localparam logic [AW:0] AF_THR = (AW+1)'(AF_LVL);

  // registered state
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        rd_valid_q, rd_valid_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;

  // decoded status
  logic [AW:0] count;
  logic        empty;
  logic        full;
  logic        almost_full;
  logic        wr_acc;
  logic        rd_acc;
  logic [DW-1:0] w_data;

  // Flags come only from the registered pointers, never from this cycle's requests.
  always_comb begin
    count       = wptr_q - rptr_q;
    empty       = (wptr_q == rptr_q);
    full        = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    almost_full = (count >= AF_THR);
  end

  // Acceptance uses this cycle's flags. A full FIFO still accepts a read, and an
  // empty FIFO still accepts a write. Data written this cycle cannot be read back
  // in the same cycle.
  always_comb begin
    wr_acc = bus.wr_en & ~full;
    rd_acc = bus.rd_en & ~empty;
  end

  // Next-state logic
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    rd_valid_d  = rd_acc;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) begin
      wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (rd_acc) begin
      rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (bus.wr_en && full) begin
      overflow_d = 1'b1;
    end
    if (bus.rd_en && empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // RAM strobes are gated by rstn so the RAM is never written or read while reset is held.
  // A write and a read never hit the same slot in the same cycle. That would need
  // a full FIFO, and a full FIFO rejects the write. So the RAM's
  // read-during-write behaviour does not matter.
  always_comb begin
    w_data = bus.wr_data;
  end

  assign bus.ram_wen     = wr_acc & rstn;
  assign bus.ram_w_addr  = wptr_q[AW-1:0];
  assign bus.ram_w_data  = w_data;
  assign bus.ram_ren     = rd_acc & rstn;
  assign bus.ram_r_addr  = rptr_q[AW-1:0];

  // RAM read latency matches the rd_valid register, so the data passes straight through.
  assign bus.rd_data     = bus.ram_r_data;
  assign bus.rd_valid    = rd_valid_q;

  assign bus.full        = full;
  assign bus.almost_full = almost_full;
  assign bus.empty       = empty;
  assign bus.count       = count;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Self-checking bench for fifo_ram_ctrl with a behavioural RAM and a queue-based reference model.
// Latency: the model predicts rd_valid/rd_data one cycle after each accepted read.
// Backpressure: the model rejects writes at 16 entries and reads at 0 entries, and keeps sticky error flags.
module tb_fifo_ram_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFL   = 12;

  logic clk;
  logic rstn;

  fifo_ram_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  fifo_ram_ctrl #(.DW(DW), .AW(AW), .AF_LVL(AFL)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dual-port RAM with a one-cycle registered read
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_wen) mem[bus.ram_w_addr] <= bus.ram_w_data;
    if (bus.ram_ren) bus.ram_r_data <= mem[bus.ram_r_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus sticky flags
  logic [DW-1:0] mq[$];
  bit            m_rv;
  logic [DW-1:0] m_rd;
  bit            m_ovf, m_unf;
  int            m_wcnt, m_rcnt;
  bit            w_ok, r_ok;
  bit            chk_en = 0;

  always @(posedge clk) begin
    if (!rstn) begin
      mq.delete();
      m_rv = 0; m_ovf = 0; m_unf = 0; m_wcnt = 0; m_rcnt = 0;
    end else begin
      w_ok = bus.wr_en && (mq.size() < DEPTH);
      r_ok = bus.rd_en && (mq.size() > 0);
      m_rv = r_ok;
      if (r_ok) begin
        m_rd = mq.pop_front();
        m_rcnt++;
      end
      if (bus.rd_en && !r_ok) m_unf = 1;
      if (bus.wr_en && !w_ok) m_ovf = 1;
      if (w_ok) begin
        mq.push_back(bus.wr_data);
        m_wcnt++;
      end
    end
  end

  // Per-cycle comparison, taken away from the active edge
  bit exp_wen, exp_ren;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_wen = rstn && bus.wr_en && (mq.size() < DEPTH);
      exp_ren = rstn && bus.rd_en && (mq.size() != 0);
      check("count",       bus.count,       mq.size());
      check("empty",       bus.empty,       mq.size() == 0);
      check("full",        bus.full,        mq.size() == DEPTH);
      check("almost_full", bus.almost_full, mq.size() >= AFL);
      check("overflow",    bus.overflow,    m_ovf);
      check("underflow",   bus.underflow,   m_unf);
      check("rd_valid",    bus.rd_valid,    m_rv);
      check("ram_wen",     bus.ram_wen,     exp_wen);
      check("ram_ren",     bus.ram_ren,     exp_ren);
      if (m_rv) check("rd_data", bus.rd_data, m_rd);
      if (exp_wen) begin
        check("ram_w_addr", bus.ram_w_addr, m_wcnt % DEPTH);
        check("ram_w_data", bus.ram_w_data, bus.wr_data);
      end
      if (exp_ren) check("ram_r_addr", bus.ram_r_addr, m_rcnt % DEPTH);
    end
  end

  // Log of words delivered to the consumer
  logic [DW-1:0] got_q[$];
  always @(negedge clk) begin
    if (chk_en && bus.rd_valid) got_q.push_back(bus.rd_data);
  end

  // One clock cycle of stimulus. The task returns 1 time unit after the edge.
  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r);
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cyc(0, '0, 0);
    rstn = 1'b1;
  endtask

  initial begin
    rstn        = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    cyc(0, '0, 0);
    chk_en = 1;
    cyc(0, '0, 0);
    rstn = 1'b1;

    // 1: reset state with idle inputs
    check("t1_empty",    bus.empty,    1);
    check("t1_full",     bus.full,     0);
    check("t1_count",    bus.count,    0);
    check("t1_rd_valid", bus.rd_valid, 0);
    check("t1_ram_wen",  bus.ram_wen,  0);
    check("t1_ram_ren",  bus.ram_ren,  0);
    cyc(0, '0, 0);

    // 2: three writes, then three reads returning the words in order
    cyc(1, 32'h11, 0);
    cyc(1, 32'h22, 0);
    cyc(1, 32'h33, 0);
    check("t2_count3", bus.count, 3);
    cyc(0, '0, 1);
    check("t2_rv0", bus.rd_valid, 1);
    check("t2_rd0", bus.rd_data,  32'h11);
    cyc(0, '0, 1);
    check("t2_rv1", bus.rd_valid, 1);
    check("t2_rd1", bus.rd_data,  32'h22);
    cyc(0, '0, 1);
    check("t2_rv2", bus.rd_valid, 1);
    check("t2_rd2", bus.rd_data,  32'h33);
    cyc(0, '0, 0);
    check("t2_rv_off", bus.rd_valid, 0);
    check("t2_count0", bus.count,    0);

    // 3: fill to 16, watching both thresholds; then one write too many
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 32'h100 + i, 0);
      if (i == 10) check("t3_af_at11",   bus.almost_full, 0);
      if (i == 11) check("t3_af_at12",   bus.almost_full, 1);
      if (i == 14) check("t3_full_at15", bus.full,        0);
    end
    check("t3_full_at16", bus.full,  1);
    check("t3_count16",   bus.count, 16);
    bus.wr_en   = 1'b1;
    bus.wr_data = 32'hDEAD;
    #1;
    check("t3_wen_blocked", bus.ram_wen, 0);
    cyc(1, 32'hDEAD, 0);
    check("t3_overflow", bus.overflow, 1);
    check("t3_count",    bus.count,    16);

    // 4: full FIFO with a read and a write in the same cycle (fresh overflow flag)
    do_reset();
    check("t4_ovf_clr", bus.overflow, 0);
    for (int i = 0; i < DEPTH; i++) cyc(1, 32'h200 + i, 0);
    cyc(1, 32'hBEEF, 1);
    check("t4_count15",  bus.count,    15);
    check("t4_overflow", bus.overflow, 1);
    check("t4_rv",       bus.rd_valid, 1);
    check("t4_rd",       bus.rd_data,  32'h200);
    for (int i = 0; i < 15; i++) cyc(0, '0, 1);
    cyc(0, '0, 0);
    check("t4_drained", bus.empty, 1);

    // 5: empty FIFO with a read and a write in the same cycle
    check("t5_unf_pre", bus.underflow, 0);
    cyc(1, 32'hAA, 1);
    check("t5_rv",        bus.rd_valid,  0);
    check("t5_underflow", bus.underflow, 1);
    check("t5_count1",    bus.count,     1);
    cyc(0, '0, 1);
    check("t5_rd", bus.rd_data, 32'hAA);

    // 6: stream 40 words across the pointer wrap, then reset with a read in flight
    do_reset();
    got_q.delete();
    for (int i = 0; i < 40; i++) cyc(1, 32'h1000 + i, i >= 8);
    check("t6_count8", bus.count, 8);
    for (int i = 0; i < 7; i++) cyc(0, '0, 1);
    check("t6_rv_inflight", bus.rd_valid, 1);
    rstn        = 1'b0;
    bus.wr_en   = 1'b1;
    bus.rd_en   = 1'b1;
    #1;
    check("t6_rst_wen", bus.ram_wen, 0);
    check("t6_rst_ren", bus.ram_ren, 0);
    cyc(1, 32'h5555, 1);
    rstn = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check("t6_rv_drop", bus.rd_valid,    0);
    check("t6_empty",   bus.empty,       1);
    check("t6_full",    bus.full,        0);
    check("t6_af",      bus.almost_full, 0);
    check("t6_count",   bus.count,       0);
    check("t6_ovf",     bus.overflow,    0);
    check("t6_unf",     bus.underflow,   0);
    check("t6_nread",   got_q.size(),    39);
    for (int k = 0; k < got_q.size() && k < 39; k++)
      check("t6_order", got_q[k], 32'h1000 + k);
    cyc(0, '0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
